// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: sequential AES InvMixColumns, one column per cycle.
// A 128-bit state is accepted in IDLE, transformed in place over four BUSY
// cycles (column 0 first), then held in DONE until the consumer takes it.
// Optional build macro INV_MIX_COLUMNS_FWD_EN adds input fwdMode, sampled at
// accept, selecting forward MixColumns (1) or the inverse transform (0).
module inv_mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic         fwdMode,
`endif
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    col_cnt;
    logic [127:0]  work;
    logic [31:0]   col_in;
    logic [31:0]   col_out;
    logic          accept;

`ifdef INV_MIX_COLUMNS_FWD_EN
    logic          fwd_mode;
`endif

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse column mix: rows {0e,0b,0d,09} rotated right per row.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
    // Forward column mix: rows {02,03,01,01} rotated right per row.
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
        end
        return {x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3],
                a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3],
                a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3],
                x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3]};
    endfunction
`endif

    assign accept   = inValid && inReady;
    assign outState = work;

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        inReady    = 1'b0;
        outValid   = 1'b0;
        case (state)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (col_cnt == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Select the column currently being transformed.
    always_comb begin
        col_in = work[127:96];
        case (col_cnt)
            2'd0: col_in = work[127:96];
            2'd1: col_in = work[95:64];
            2'd2: col_in = work[63:32];
            2'd3: col_in = work[31:0];
            default: col_in = work[127:96];
        endcase
    end

    // Column transform, mode chosen by the value latched at accept.
    always_comb begin
`ifdef INV_MIX_COLUMNS_FWD_EN
        col_out = fwd_mode ? fwd_col(col_in) : inv_col(col_in);
`else
        col_out = inv_col(col_in);
`endif
    end

    // Working register: load on accept, rewrite one column per BUSY cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work    <= '0;
            col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_FWD_EN
            fwd_mode <= 1'b0;
`endif
        end else begin
            if (state == IDLE && accept) begin
                work    <= inState;
                col_cnt <= '0;
`ifdef INV_MIX_COLUMNS_FWD_EN
                fwd_mode <= fwdMode;
`endif
            end else if (state == BUSY) begin
                case (col_cnt)
                    2'd0: work[127:96] <= col_out;
                    2'd1: work[95:64]  <= col_out;
                    2'd2: work[63:32]  <= col_out;
                    2'd3: work[31:0]   <= col_out;
                    default: work[127:96] <= col_out;
                endcase
                col_cnt <= col_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Testbench for inv_mix_columns_seq: scoreboard of expected states pushed at
// accept and compared when outValid is seen. Define INV_MIX_COLUMNS_FWD_EN
// to include the forward/inverse round trip.
module tb_inv_mix_columns_seq;

    localparam logic [127:0] V_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] V_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [127:0] inState;
    logic         fwdMode;
    logic         outValid;
    logic         outReady;
    logic [127:0] outState;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] sb_q[$];
    int           acc_q[$];

    always #5 clk = ~clk;

    inv_mix_columns_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .inState  (inState),
`ifdef INV_MIX_COLUMNS_FWD_EN
        .fwdMode  (fwdMode),
`endif
        .outValid (outValid),
        .outReady (outReady),
        .outState (outState)
    );

    // Reference GF(2^8) multiply by shift-and-add, reduction 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        logic       carry;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            carry = a[7];
            a = {a[6:0], 1'b0};
            if (carry) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int k, input logic fwd);
        case (k)
            0: return fwd ? 8'h02 : 8'h0e;
            1: return fwd ? 8'h03 : 8'h0b;
            2: return fwd ? 8'h01 : 8'h0d;
            default: return fwd ? 8'h01 : 8'h09;
        endcase
    endfunction

    // Circulant matrix product applied to each of the four columns.
    function automatic logic [127:0] model(input logic [127:0] st, input logic fwd);
        logic [127:0] res = '0;
        logic [31:0]  col;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            col = st[127 - 32*c -: 32];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef((j - r + 4) % 4, fwd), col[31 - 8*j -: 8]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Offer a state, wait (bounded) for inReady, record expectation at accept.
    task automatic send(input logic [127:0] st, input logic fwd);
        inState = st;
        fwdMode = fwd;
        inValid = 1'b1;
        for (int i = 0; i < 20 && inReady !== 1'b1; i++) tick();
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL send_ready got %b want 1", inReady);
            inValid = 1'b0;
            return;
        end
        tick();
        sb_q.push_back(model(st, fwd));
        acc_q.push_back(cyc);
        inValid = 1'b0;
    endtask

    // Wait (bounded) for outValid, then pop and compare against the scoreboard.
    task automatic sb_compare(input string name);
        logic [127:0] exp;
        int           acc;
        for (int i = 0; i < 20 && outValid !== 1'b1; i++) tick();
        checks++;
        if (outValid !== 1'b1 || sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout outValid=%b pending=%0d want outValid=1", name, outValid, sb_q.size());
            return;
        end
        exp = sb_q.pop_front();
        acc = acc_q.pop_front();
        checks++;
        if (outState !== exp) begin
            errors++;
            $display("FAIL %s_data got %h want %h (accept cycle %0d)", name, outState, exp, acc);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        inValid  = 1'b1;
        inState  = rand_state();
        fwdMode  = 1'b0;
        outReady = 1'b0;
        tick();
        tick();
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || outState !== '0) begin
            errors++;
            $display("FAIL reset_state got inReady=%b outValid=%b outState=%h want 1 0 0",
                     inReady, outValid, outState);
        end
        rst_n   = 1'b1;
        inValid = 1'b0;
        tick();
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept got inReady=%b outValid=%b want 1 0", inReady, outValid);
        end
    endtask

    task automatic test_single();
        int n = 0;
        outReady = 1'b1;
        send(V_IN, 1'b0);
        checks++;
        if (inReady !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_ready got %b want 0", inReady);
        end
        while (outValid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (acc_q.size() == 0 || cyc - acc_q[0] != 4) begin
            errors++;
            $display("FAIL single_latency got %0d want 4", acc_q.size() ? cyc - acc_q[0] : -1);
        end
        checks++;
        if (outState !== V_OUT) begin
            errors++;
            $display("FAIL single_vector got %h want %h", outState, V_OUT);
        end
        sb_compare("single");
        tick();
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL single_release got outValid=%b inReady=%b want 0 1", outValid, inReady);
        end
    endtask

    task automatic test_patterns();
        logic [127:0] st;
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            st = (i == 0) ? '0 : (i == 1) ? '1 : rand_state();
            send(st, 1'b0);
            sb_compare("pattern");
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        bit           bad_v = 0, bad_s = 0, bad_r = 0;
        outReady = 1'b0;
        send(rand_state(), 1'b0);
        for (int i = 0; i < 20 && outValid !== 1'b1; i++) tick();
        held = outState;
        for (int i = 0; i < 10; i++) begin
            inValid = 1'b1;
            inState = ~held;
            tick();
            if (outValid !== 1'b1) bad_v = 1;
            if (outState !== held) bad_s = 1;
            if (inReady !== 1'b0) bad_r = 1;
        end
        inValid = 1'b0;
        checks++;
        if (bad_v) begin errors++; $display("FAIL bp_valid_held got drop want outValid=1"); end
        checks++;
        if (bad_s) begin errors++; $display("FAIL bp_state_stable got %h want %h", outState, held); end
        checks++;
        if (bad_r) begin errors++; $display("FAIL bp_inready got 1 want 0"); end
        sb_compare("backpressure");
        outReady = 1'b1;
        tick();
        checks++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got outValid=%b inReady=%b want 0 1", outValid, inReady);
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        outReady = 1'b1;
        send(rand_state(), 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if (sb_q.size() != 0) begin
            void'(sb_q.pop_back());
            void'(acc_q.pop_back());
        end
        checks++;
        if (inReady !== 1'b1 || outValid !== 1'b0 || outState !== '0) begin
            errors++;
            $display("FAIL midreset_state got inReady=%b outValid=%b outState=%h want 1 0 0",
                     inReady, outValid, outState);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (outValid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midreset_no_output got outValid=1 want 0"); end
        send({16{8'hc6}}, 1'b0);
        sb_compare("midreset_c6");
        checks++;
        if (outState !== {16{8'hc6}}) begin
            errors++;
            $display("FAIL midreset_c6_literal got %h want %h", outState, {16{8'hc6}});
        end
        tick();
    endtask

    task automatic test_ignored_input();
        int n = 0;
        outReady = 1'b1;
        send(rand_state(), 1'b0);
        while (outValid !== 1'b1 && n < 10) begin
            inValid = 1'b1;
            inState = rand_state();
            tick();
            n++;
        end
        inValid = 1'b0;
        sb_compare("ignored");
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] b_state = rand_state();
        int           acc_cyc[2];
        int           n_acc = 0, n_out = 0, acc;
        bit           acc_now;
        logic [127:0] exp;
        outReady = 1'b1;
        inState  = rand_state();
        fwdMode  = 1'b0;
        inValid  = 1'b1;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            acc_now = (inValid === 1'b1) && (inReady === 1'b1);
            if (outValid === 1'b1 && sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                acc = acc_q.pop_front();
                checks++;
                if (outState !== exp || cyc - acc != 4) begin
                    errors++;
                    $display("FAIL b2b_result%0d got %h lat %0d want %h lat 4", n_out, outState, cyc - acc, exp);
                end
                n_out++;
            end
            tick();
            if (acc_now && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                sb_q.push_back(model(inState, 1'b0));
                acc_q.push_back(cyc);
                n_acc++;
                if (n_acc == 1) inState = b_state;
                else inValid = 1'b0;
            end
        end
        inValid = 1'b0;
        checks++;
        if (n_out != 2 || n_acc != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d outputs %0d accepts want 2 2", n_out, n_acc);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != 6) begin
                errors++;
                $display("FAIL b2b_spacing got %0d want 6", acc_cyc[1] - acc_cyc[0]);
            end
        end
        tick();
    endtask

`ifdef INV_MIX_COLUMNS_FWD_EN
    task automatic test_roundtrip();
        logic [127:0] fwd_res;
        outReady = 1'b1;
        send({4{32'hdb135345}}, 1'b1);
        sb_compare("roundtrip_fwd");
        fwd_res = outState;
        checks++;
        if (outState !== {4{32'h8e4da1bc}}) begin
            errors++;
            $display("FAIL roundtrip_fwd_literal got %h want %h", outState, {4{32'h8e4da1bc}});
        end
        tick();
        send(fwd_res, 1'b0);
        sb_compare("roundtrip_inv");
        checks++;
        if (outState !== {4{32'hdb135345}}) begin
            errors++;
            $display("FAIL roundtrip_inv_literal got %h want %h", outState, {4{32'hdb135345}});
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_backpressure();
        test_mid_reset();
        test_ignored_input();
        test_back_to_back();
`ifdef INV_MIX_COLUMNS_FWD_EN
        test_roundtrip();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
